channel_arbiter: RTL and testbench
==================================

CHANNEL_ARBITER -- requirements
Module: channel_arbiter

Interface
REQ-001 Parameter NCH, default 8: number of destination channels (fixed at 8 in this revision).
REQ-002 Parameter DW, default 32: FIFO data width.
REQ-003 Parameter PW, default 8: per-channel priority width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 valid_dst  input  NCH  per-channel read request; bit i = channel i.
REQ-007 priority_dst  input  NCH*PW  per-channel priority, channel i at bits [i*PW +: PW]; larger value wins.
REQ-008 fifo_empty  input  1  FIFO empty flag.
REQ-009 fifo_rd_en  output  1  FIFO read strobe, one cycle per grant.
REQ-010 fifo_rdata  input  DW  FIFO read data, valid the cycle after fifo_rd_en.
REQ-011 data_dst  output  NCH*DW  per-channel data register, channel i at bits [i*DW +: DW].
REQ-012 ready_dst  output  NCH  per-channel one-cycle delivery pulse.
REQ-013 grant_id  output  3  index of the current or last granted channel.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, ARB, READ, CAPT, RESP; exactly one active.
REQ-016 IDLE -> ARB when |valid_dst and !fifo_empty; otherwise stay in IDLE.
REQ-017 ARB: recompute from current inputs; if no valid or fifo_empty -> IDLE with no grant; else register winner into grant_id -> READ.
REQ-018 Winner = valid channel with maximum priority; priority 0 is a legal, grantable value.
REQ-019 Ties: first tied channel scanning upward from rr_ptr, wrapping 7 -> 0.
REQ-020 READ: fifo_rd_en = 1 for exactly this one cycle -> CAPT; fifo_rd_en = 0 in all other states.
REQ-021 CAPT: fifo_rdata captured into an internal data register at the end of the cycle -> RESP.
REQ-022 RESP: data_dst[grant_id] loads captured data, ready_dst[grant_id] = 1 for this cycle only, rr_ptr <= (grant_id+1) mod 8 -> IDLE.
REQ-023 Latency: valid sampled in IDLE at edge N -> fifo_rd_en high in cycle N+2 -> ready_dst pulse in cycle N+4; minimum 5 cycles per transfer.
REQ-024 Non-granted channels' data_dst slices hold their value; a slice changes only on that channel's RESP.
REQ-025 At most one ready_dst bit high in any cycle; ready_dst = 0 outside RESP.
REQ-026 Once READ is entered the transfer completes to grant_id even if its valid drops or other requests change.
REQ-027 fifo_empty and valid_dst are ignored in READ, CAPT and RESP.
REQ-028 Winner must keep valid high until its ready pulse; this is a requester obligation and is not checked.
REQ-029 Priority changes during READ/CAPT/RESP take effect at the next ARB.

Reset
REQ-030 Reset asserted: state = IDLE, rr_ptr = 0, grant_id = 0, fifo_rd_en = 0, ready_dst = 0, data_dst = 0, busy = 0, immediately and without a clock edge.
REQ-031 Reset asserted mid-transfer aborts it with no ready pulse; a FIFO word already read is discarded.
REQ-032 After reset release, the first ARB occurs no earlier than the first rising edge with reset low.

Verification
REQ-033 Bench SHALL cover: reset, valid_dst=8'h04, prio2=5, FIFO holds 32'hA5A5_0001 -> rd_en at N+2, ready_dst=8'h04 at N+4, data_dst ch2=32'hA5A5_0001, grant_id=2.
REQ-034 Bench SHALL cover: valid_dst=8'hFF, all priorities 3, rr_ptr=0, FIFO holds 8 words -> grants 0,1,...,7 in order, one ready per 5 cycles.
REQ-035 Bench SHALL cover: valid ch1 prio 9 and ch6 prio 200 -> ch6 served first, then ch1; each receives the next FIFO word in order.
REQ-036 Bench SHALL cover: valid_dst=8'h01 with fifo_empty=1 -> stays IDLE, fifo_rd_en never asserted, busy=0.
REQ-037 Bench SHALL cover: reset pulsed during CAPT -> no ready_dst pulse, all outputs 0, and the next request is granted normally starting from rr_ptr=0.
REQ-038 Bench SHALL cover: ch3 valid drops during READ -> ready_dst=8'h08 still pulses at N+4 with the read word.

Source files
------------

// File: rtl/channel_arbiter.sv
// Priority arbiter that pops one FIFO word per grant and delivers it to the winning channel.
// Each transfer walks IDLE -> ARB -> READ -> CAPT -> RESP; ties rotate round-robin.
module channel_arbiter #(
   parameter int NCH = 8,
   parameter int DW  = 32,
   parameter int PW  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NCH-1:0]      valid_dst,
   input  logic [NCH*PW-1:0]   priority_dst,
   input  logic                fifo_empty,
   output logic                fifo_rd_en,
   input  logic [DW-1:0]       fifo_rdata,
   output logic [NCH*DW-1:0]   data_dst,
   output logic [NCH-1:0]      ready_dst,
   output logic [2:0]          grant_id,
   output logic                busy
);

   typedef enum logic [2:0] {IDLE, ARB, READ, CAPT, RESP} state_t;

   state_t          state;
   logic [2:0]      rr_ptr;
   logic [PW-1:0]   prio [NCH];
   logic [2:0]      scan_idx [NCH];
   logic            win_found;
   logic [2:0]      win_id;
   logic [PW-1:0]   win_prio;

   // scan_idx[k] is the k-th channel visited when scanning upward from rr_ptr.
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
         assign prio[gi]     = priority_dst[gi*PW +: PW];
         assign scan_idx[gi] = rr_ptr + 3'(gi);
      end
   endgenerate

   // Strict greater-than keeps the earliest channel in scan order on a tie.
   always_comb begin
      win_found = 1'b0;
      win_id    = 3'd0;
      win_prio  = '0;
      for (int k = 0; k < NCH; k++) begin
         if (valid_dst[scan_idx[k]] && (!win_found || (prio[scan_idx[k]] > win_prio))) begin
            win_found = 1'b1;
            win_id    = scan_idx[k];
            win_prio  = prio[scan_idx[k]];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rr_ptr     <= 3'd0;
         grant_id   <= 3'd0;
         fifo_rd_en <= 1'b0;
         ready_dst  <= '0;
         data_dst   <= '0;
         busy       <= 1'b0;
      end else begin
         fifo_rd_en <= 1'b0;
         ready_dst  <= '0;
         case (state)
            IDLE: begin
               if (|valid_dst && !fifo_empty) begin
                  state <= ARB;
                  busy  <= 1'b1;
               end
            end
            ARB: begin
               if (win_found && !fifo_empty) begin
                  grant_id   <= win_id;
                  fifo_rd_en <= 1'b1;
                  state      <= READ;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            READ: begin
               state <= CAPT;
            end
            CAPT: begin
               // The channel's own data slice is the capture register, so the
               // word is already visible while its ready pulse is high.
               data_dst[int'(grant_id)*DW +: DW] <= fifo_rdata;
               ready_dst[grant_id]              <= 1'b1;
               state                            <= RESP;
            end
            RESP: begin
               rr_ptr <= grant_id + 3'd1;
               state  <= IDLE;
               busy   <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_channel_arbiter.sv
// Self-checking bench for channel_arbiter: directed table, corner sequences and
// randomized transfers checked against a transaction-level model.
module tb_channel_arbiter;

   logic          clk;
   logic          reset;
   logic [7:0]    valid_dst;
   logic [63:0]   priority_dst;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [31:0]   fifo_rdata;
   logic [255:0]  data_dst;
   logic [7:0]    ready_dst;
   logic [2:0]    grant_id;
   logic          busy;

   channel_arbiter #(.NCH(8), .DW(32), .PW(8)) dut (
      .clk(clk), .reset(reset), .valid_dst(valid_dst), .priority_dst(priority_dst),
      .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata),
      .data_dst(data_dst), .ready_dst(ready_dst), .grant_id(grant_id), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model: words are written by the stimulus, popped one per read strobe.
   logic [31:0] fifo_mem [0:255];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic        force_empty = 1'b0;
   assign fifo_empty = force_empty || (rd_ptr == wr_ptr);
   always @(posedge clk) begin
      if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
         fifo_rdata <= fifo_mem[rd_ptr];
         rd_ptr     <= rd_ptr + 1;
      end
   end

   int          checks = 0;
   int          errors = 0;
   logic [31:0] data_model [8];
   int          rr_model = 0;

   typedef struct {
      logic [7:0]  valid;
      logic [63:0] prio;
      logic [31:0] word;
      int          exp_ch;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      fifo_mem[wr_ptr] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   function automatic logic [255:0] model_bus();
      logic [255:0] b;
      for (int i = 0; i < 8; i++) b[i*32 +: 32] = data_model[i];
      return b;
   endfunction

   // Largest priority among valid channels, then the first holder of it from rr upward.
   function automatic int model_winner(input logic [7:0] v, input logic [63:0] p, input int rr);
      int best = -1;
      for (int i = 0; i < 8; i++)
         if (v[i] && int'(p[i*8 +: 8]) > best) best = int'(p[i*8 +: 8]);
      for (int k = 0; k < 8; k++) begin
         int c = (rr + k) % 8;
         if (v[c] && int'(p[c*8 +: 8]) == best) return c;
      end
      return -1;
   endfunction

   // Called at a negedge with the DUT idle and inputs set. mode 1 drops valid
   // during READ, mode 2 scrambles all requests/priorities and forces empty then.
   task automatic run_xfer(input int exp_ch, input logic [31:0] exp_word, input int mode, input string tag);
      int rd_at = -1;
      int rdy_at = -1;
      for (int c = 1; c <= 12 && rdy_at < 0; c++) begin
         @(negedge clk);
         if (fifo_rd_en) begin
            rd_at = (rd_at < 0) ? c : 99;
            if (mode == 1) valid_dst = 8'h00;
            if (mode == 2) begin
               valid_dst    = 8'($urandom);
               priority_dst = {$urandom, $urandom};
               force_empty  = 1'b1;
            end
         end
         if (ready_dst != 8'h00) rdy_at = c;
      end
      data_model[exp_ch] = exp_word;
      rr_model = (exp_ch + 1) % 8;
      $display("xfer %s: ch %0d word %h rd@%0d rdy@%0d", tag, exp_ch, exp_word, rd_at, rdy_at);
      chk({tag, " rd_en_cycle"}, 256'(rd_at), 256'(2));
      chk({tag, " ready_cycle"}, 256'(rdy_at), 256'(4));
      chk({tag, " ready_dst"}, 256'(ready_dst), 256'(8'h01 << exp_ch));
      chk({tag, " grant_id"}, 256'(grant_id), 256'(exp_ch));
      chk({tag, " data_dst"}, data_dst, model_bus());
      @(negedge clk);
      chk({tag, " idle_after"}, 256'({ready_dst, busy, fifo_rd_en}), 256'(0));
      force_empty = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic saw_rd;
      logic saw_busy;
      logic saw_rdy;
      int   pulse_at [8];
      int   npulse;
      int   w;

      reset = 1'b1; valid_dst = 8'h00; priority_dst = '0;
      for (int i = 0; i < 8; i++) data_model[i] = 32'h0;
      #1;
      chk("reset_outputs", {fifo_rd_en, ready_dst, grant_id, busy}, 256'(0));
      chk("reset_data", data_dst, 256'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Request with an empty FIFO must never start a transfer.
      valid_dst = 8'h01; priority_dst = 64'h1;
      saw_rd = 1'b0; saw_busy = 1'b0;
      repeat (10) begin
         @(negedge clk);
         saw_rd   = saw_rd | fifo_rd_en;
         saw_busy = saw_busy | busy;
      end
      $display("xfer empty_fifo: rd_seen %0b busy_seen %0b", saw_rd, saw_busy);
      chk("empty_no_rd_en", 256'(saw_rd), 256'(0));
      chk("empty_no_busy", 256'(saw_busy), 256'(0));
      valid_dst = 8'h00;

      // All channels requesting at equal priority: strict rotation, one pulse per 5 cycles.
      for (int k = 0; k < 8; k++) push(32'hC000_0000 + 32'(k));
      @(negedge clk);
      valid_dst = 8'hFF; priority_dst = {8{8'h03}};
      npulse = 0;
      for (int c = 1; c <= 60 && npulse < 8; c++) begin
         @(negedge clk);
         if (ready_dst != 8'h00) begin
            pulse_at[npulse] = c;
            data_model[npulse] = 32'hC000_0000 + 32'(npulse);
            $display("xfer rr_sweep: pulse %0d ready %h grant %0d at %0d", npulse, ready_dst, grant_id, c);
            chk($sformatf("rr_sweep%0d ready_dst", npulse), 256'(ready_dst), 256'(8'h01 << npulse));
            chk($sformatf("rr_sweep%0d data", npulse), data_dst, model_bus());
            if (npulse > 0)
               chk($sformatf("rr_sweep%0d gap", npulse), 256'(c - pulse_at[npulse-1]), 256'(5));
            npulse++;
            if (npulse == 8) valid_dst = 8'h00;
         end
      end
      chk("rr_sweep count", 256'(npulse), 256'(8));
      rr_model = 0;
      @(negedge clk);

      // Directed table, applied back to back; FIFO preloaded with every word in order.
      tbl[0] = '{8'h04, 64'h0000_0000_0005_0000, 32'hA5A5_0001, 2};
      tbl[1] = '{8'h42, 64'h00C8_0000_0000_0900, 32'hB000_0001, 6};
      tbl[2] = '{8'h02, 64'h00C8_0000_0000_0900, 32'hB000_0002, 1};
      tbl[3] = '{8'h11, 64'h0000_0000_0000_0000, 32'h0000_0011, 4};
      tbl[4] = '{8'h81, 64'h0A00_0000_0000_000A, 32'h8100_0001, 7};
      tbl[5] = '{8'h81, 64'h0A00_0000_0000_000A, 32'h8100_0002, 0};
      tbl[6] = '{8'h0C, 64'h0000_0000_FF01_0000, 32'h0C0C_0003, 3};
      for (int i = 0; i < 7; i++) push(tbl[i].word);
      for (int i = 0; i < 7; i++) begin
         valid_dst = tbl[i].valid; priority_dst = tbl[i].prio;
         run_xfer(tbl[i].exp_ch, tbl[i].word, 0, $sformatf("tbl%0d", i));
      end

      // Winner's valid drops during READ: delivery still completes.
      push(32'h3333_0038);
      valid_dst = 8'h08; priority_dst = 64'h0000_0000_4000_0000;
      run_xfer(3, 32'h3333_0038, 1, "drop_valid");

      // Reset asserted during CAPT aborts the transfer and discards the word.
      push(32'hDEAD_0037);
      valid_dst = 8'h20; priority_dst = 64'h0000_0100_0000_0000;
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("capt_reset outputs", {fifo_rd_en, ready_dst, grant_id, busy}, 256'(0));
      chk("capt_reset data", data_dst, 256'(0));
      valid_dst = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) data_model[i] = 32'h0;
      rr_model = 0;
      saw_rdy = 1'b0;
      repeat (6) begin
         @(negedge clk);
         saw_rdy = saw_rdy | (ready_dst != 8'h00) | busy;
      end
      $display("xfer capt_reset: activity after reset %0b", saw_rdy);
      chk("capt_reset no_pulse", 256'(saw_rdy), 256'(0));
      push(32'h1234_5678);
      valid_dst = 8'h11; priority_dst = {8{8'h07}};
      run_xfer(0, 32'h1234_5678, 0, "post_reset");

      // Randomized transfers against the model.
      for (int n = 0; n < 40; n++) begin
         int exp;
         valid_dst = 8'($urandom_range(1, 255));
         for (int i = 0; i < 8; i++) priority_dst[i*8 +: 8] = 8'($urandom_range(0, 3));
         if (n % 5 == 0) priority_dst[8*$urandom_range(0, 7) +: 8] = 8'($urandom);
         w = int'($urandom);
         push(32'(w));
         exp = model_winner(valid_dst, priority_dst, rr_model);
         run_xfer(exp, 32'(w), n % 3, $sformatf("rand%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
